implication_responder: RTL and testbench
========================================

IMPLICATION_RESPONDER -- requirements
Module: implication_responder

Interface
REQ-001 The block SHALL have one clock and reset: clk (rising edge); rst is synchronous and active-high.
REQ-002 Parameter KIND, default NON_OVERLAPPING, selects overlapping (same-cycle) or non-overlapping (delayed) response (implication_kind_e).
REQ-003 Parameter DELAY, default 1, sets the response latency in cycles; it is ignored when KIND=OVERLAPPING and legal in 1..16 otherwise.
REQ-004 Parameter MAX_PENDING, default 4, sets the in-flight response limit; legal range 1..16.
REQ-005 Port clk, input, 1 bit: clock.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port antecedent, input, 1 bit: request pulse sampled each rising edge.
REQ-008 Port inject_fail, input, 1 bit: suppresses the response to the antecedent sampled on the same edge.
REQ-009 Port consequent, output, 1 bit: response pulse.
REQ-010 Port pending, output, $clog2(MAX_PENDING+1) bits: count of accepted, not-yet-retired requests.
REQ-011 Port busy, output, 1 bit: state==ACTIVE.
REQ-012 Port dropped, output, 1 bit: one-cycle pulse marking a request rejected on the previous edge.
REQ-013 Port overflow, output, 1 bit: sticky flag, set on any drop.

Function
REQ-014 KIND=OVERLAPPING: consequent SHALL equal antecedent & ~inject_fail & ~rst combinationally; pending, busy, dropped and overflow SHALL be held at 0.
REQ-015 KIND=NON_OVERLAPPING: a request accepted at edge t SHALL drive consequent=1 as sampled at edge t+DELAY, unless inject_fail was 1 at edge t.
REQ-016 A suppressed request SHALL still occupy a pending slot until t+DELAY.
REQ-017 An entry SHALL count in pending from edge t+1 through edge t+DELAY inclusive; it retires in the cycle its consequent is (or would be) driven.
REQ-018 Accept rule: antecedent=1 SHALL be accepted when pending<MAX_PENDING, or when an entry retires in the same cycle.
REQ-019 A rejected request SHALL never produce a consequent; dropped=1 at t+1 and overflow=1 from t+1 until reset.
REQ-020 On simultaneous accept and retire, pending SHALL be unchanged; on accept only it increments by 1; on retire only it decrements by 1; it never wraps.
REQ-021 Back-to-back requests every cycle with DELAY=1 SHALL yield consequent continuously high and pending steady at 1, with no drops for any MAX_PENDING.
REQ-022 State machine: IDLE->ACTIVE when pending becomes nonzero; ACTIVE->IDLE when pending returns to 0; no other states.
REQ-023 Consequent SHALL be a registered output when KIND=NON_OVERLAPPING.

Reset
REQ-024 rst=1 at an edge SHALL clear all in-flight entries, set pending=0, state=IDLE, and set consequent, busy, dropped and overflow to 0.
REQ-025 Responses in flight at reset SHALL be discarded and never emitted.
REQ-026 antecedent sampled while rst=1 SHALL be ignored.

Structure
REQ-027 implication_pkg SHALL hold implication_kind_e {OVERLAPPING, NON_OVERLAPPING} and responder_state_e {IDLE, ACTIVE}.
REQ-028 The delay path SHALL be one sub-module, implication_delay_line: DELAY-stage shift of {valid, suppress} bits with synchronous clear.

Verification
REQ-029 NON_OVERLAPPING, DELAY=3, MAX_PENDING=4: single antecedent at edge 5 -> consequent=1 at edge 8 only; pending=1 at edges 6..8 and 0 at edge 9.
REQ-030 DELAY=3, MAX_PENDING=2: antecedent at edges 0,1,2 -> consequent at 3 and 4 only; dropped=1 at 3; overflow=1 from 3 onward.
REQ-031 DELAY=1, MAX_PENDING=1: antecedent held high for edges 0..9 -> consequent=1 at edges 1..10, pending=1 throughout, dropped never set.
REQ-032 DELAY=2: antecedent plus inject_fail at edge 4 -> no consequent at 6; pending=1 at edges 5..6; busy=1 at edges 5..6.
REQ-033 DELAY=4: antecedent at edges 0 and 1, rst at edge 2 -> no consequent ever; pending=0 and busy=0 from edge 3.
REQ-034 OVERLAPPING: antecedent=1 with inject_fail=0 -> consequent=1 in the same cycle; with inject_fail=1 -> consequent=0.

Source files
------------

// File: rtl/implication_pkg.sv
// Shared types and helpers for the implication responder and its delay line.
package implication_pkg;

    typedef enum logic {OVERLAPPING, NON_OVERLAPPING} implication_kind_e;

    typedef enum logic {IDLE, ACTIVE} responder_state_e;

    function automatic int unsigned pending_width(input int unsigned max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/implication_delay_line.sv
// Fixed-latency shift of {valid, suppress} per accepted request, with synchronous clear.
module implication_delay_line #(
    parameter int unsigned DELAY = 1
) (
    input  logic clk,
    input  logic clear,
    input  logic in_valid,
    input  logic in_suppress,
    output logic out_valid,
    output logic out_suppress
);

    logic [DELAY-1:0] valid_q;
    logic [DELAY-1:0] suppress_q;
    logic [DELAY-1:0] valid_d;
    logic [DELAY-1:0] suppress_d;

    // Suppress is only meaningful alongside valid, so it is masked on entry.
    generate
        if (DELAY > 1) begin : g_multi
            assign valid_d    = {valid_q[DELAY-2:0], in_valid};
            assign suppress_d = {suppress_q[DELAY-2:0], in_suppress & in_valid};
        end else begin : g_single
            assign valid_d    = in_valid;
            assign suppress_d = in_suppress & in_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q    <= '0;
            suppress_q <= '0;
        end else begin
            valid_q    <= valid_d;
            suppress_q <= suppress_d;
        end
    end

    assign out_valid    = valid_q[DELAY-1];
    assign out_suppress = suppress_q[DELAY-1];

endmodule

// File: rtl/implication_responder.sv
// Responds to each antecedent pulse with a consequent pulse, either combinationally
// or after a fixed delay with a bounded number of requests in flight.
module implication_responder
    import implication_pkg::*;
#(
    parameter implication_kind_e KIND        = NON_OVERLAPPING,
    parameter int unsigned       DELAY       = 1,
    parameter int unsigned       MAX_PENDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  antecedent,
    input  logic                                  inject_fail,
    output logic                                  consequent,
    output logic [pending_width(MAX_PENDING)-1:0] pending,
    output logic                                  busy,
    output logic                                  dropped,
    output logic                                  overflow
);

    localparam int unsigned   PW         = pending_width(MAX_PENDING);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
    localparam bit            NON_OVL    = (KIND == NON_OVERLAPPING);
    localparam int unsigned   LINE_DELAY = NON_OVL ? DELAY : 1;

    logic             line_valid;
    logic             line_suppress;
    logic             retire;
    logic             accept;
    logic             reject;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_d;
    responder_state_e state_q;
    responder_state_e state_d;
    logic             dropped_q;
    logic             overflow_q;

    // The entry at the end of the line is the one driving consequent this cycle;
    // its slot frees up at the coming edge, so a new request may take it.
    assign retire = line_valid;
    assign accept = NON_OVL & antecedent & ((pending_q < PEND_MAX) | retire);
    assign reject = NON_OVL & antecedent & ~accept;

    implication_delay_line #(
        .DELAY (LINE_DELAY)
    ) u_delay_line (
        .clk          (clk),
        .clear        (rst),
        .in_valid     (accept),
        .in_suppress  (inject_fail),
        .out_valid    (line_valid),
        .out_suppress (line_suppress)
    );

    always_comb begin
        pending_d = pending_q;
        case ({accept, retire})
            2'b10:   pending_d = pending_q + PW'(1);
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (pending_d != '0) state_d = ACTIVE;
            ACTIVE: if (pending_d == '0) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            state_q    <= IDLE;
            dropped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            state_q    <= state_d;
            dropped_q  <= reject;
            overflow_q <= overflow_q | reject;
        end
    end

    assign consequent = NON_OVL ? (line_valid & ~line_suppress)
                                : (antecedent & ~inject_fail & ~rst);
    assign pending    = NON_OVL ? pending_q : '0;
    assign busy       = NON_OVL ? (state_q == ACTIVE) : 1'b0;
    assign dropped    = NON_OVL ? dropped_q : 1'b0;
    assign overflow   = NON_OVL ? overflow_q : 1'b0;

endmodule

// File: tb/tb_implication_responder.sv
// Bench: five delayed-response configurations and one same-cycle instance share one stimulus
// stream; a due-time scoreboard predicts every output, and directed tables pin key traces.
module tb_implication_responder;
    import implication_pkg::*;

    localparam int NI = 5;
    localparam int DLY [NI] = '{3, 3, 1, 2, 4};
    localparam int MPN [NI] = '{4, 2, 1, 4, 4};

    logic clk;
    logic rst;
    logic ant;
    logic inj;

    logic       cons_w [NI+1];
    logic       busy_w [NI+1];
    logic       drop_w [NI+1];
    logic       ovf_w  [NI+1];
    int         pend_w [NI+1];
    logic [2:0] pend0;
    logic [1:0] pend1;
    logic [0:0] pend2;
    logic [2:0] pend3;
    logic [2:0] pend4;
    logic [2:0] pend5;

    assign pend_w[0] = int'(pend0);
    assign pend_w[1] = int'(pend1);
    assign pend_w[2] = int'(pend2);
    assign pend_w[3] = int'(pend3);
    assign pend_w[4] = int'(pend4);
    assign pend_w[5] = int'(pend5);

    implication_responder #(.DELAY(3), .MAX_PENDING(4)) u_d3m4 (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[0]),
        .pending(pend0), .busy(busy_w[0]), .dropped(drop_w[0]), .overflow(ovf_w[0]));
    implication_responder #(.DELAY(3), .MAX_PENDING(2)) u_d3m2 (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[1]),
        .pending(pend1), .busy(busy_w[1]), .dropped(drop_w[1]), .overflow(ovf_w[1]));
    implication_responder #(.DELAY(1), .MAX_PENDING(1)) u_d1m1 (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[2]),
        .pending(pend2), .busy(busy_w[2]), .dropped(drop_w[2]), .overflow(ovf_w[2]));
    implication_responder #(.DELAY(2), .MAX_PENDING(4)) u_d2m4 (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[3]),
        .pending(pend3), .busy(busy_w[3]), .dropped(drop_w[3]), .overflow(ovf_w[3]));
    implication_responder #(.DELAY(4), .MAX_PENDING(4)) u_d4m4 (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[4]),
        .pending(pend4), .busy(busy_w[4]), .dropped(drop_w[4]), .overflow(ovf_w[4]));
    implication_responder #(.KIND(OVERLAPPING)) u_ovl (
        .clk(clk), .rst(rst), .antecedent(ant), .inject_fail(inj), .consequent(cons_w[5]),
        .pending(pend5), .busy(busy_w[5]), .dropped(drop_w[5]), .overflow(ovf_w[5]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard entry: one accepted request and the edge at which its response is due.
    typedef struct {
        int inst;
        int due;
        bit sup;
    } entry_t;

    typedef struct {
        logic [15:0] ant;
        logic [15:0] inj;
        logic [15:0] rst;
        int          tgt;
        logic [16:0] cons;
        logic [16:0] busy;
        logic [16:0] drop;
        logic [16:0] ovf;
    } vec_t;

    typedef struct {
        logic a;
        logic f;
        logic r;
        logic y;
    } ovl_t;

    entry_t sb[$];
    bit     exp_cons [NI];
    bit     exp_drop [NI];
    bit     exp_ovf  [NI];
    int     exp_pend [NI];
    int     cyc;
    int     n_checks;
    int     n_errors;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic a, input logic f, input logic r);
        entry_t keep[$];
        entry_t e;
        int     cnt [NI];
        bit     ret [NI];
        bit     acc;
        for (int i = 0; i < NI; i++) begin
            cnt[i] = 0;
            ret[i] = 0;
        end
        foreach (sb[j]) begin
            cnt[sb[j].inst]++;
            if (sb[j].due == cyc) ret[sb[j].inst] = 1;
        end
        foreach (sb[j]) if (!r && sb[j].due != cyc) keep.push_back(sb[j]);
        for (int i = 0; i < NI; i++) begin
            acc = !r && a && (cnt[i] < MPN[i] || ret[i]);
            if (acc) begin
                e.inst = i;
                e.due  = cyc + DLY[i];
                e.sup  = f;
                keep.push_back(e);
            end
            if (r) begin
                exp_drop[i] = 0;
                exp_ovf[i]  = 0;
            end else begin
                exp_drop[i] = a && !acc;
                exp_ovf[i]  = exp_ovf[i] | exp_drop[i];
            end
            exp_pend[i] = 0;
            exp_cons[i] = 0;
        end
        sb = keep;
        foreach (sb[j]) begin
            exp_pend[sb[j].inst]++;
            if (sb[j].due == cyc + 1 && !sb[j].sup) exp_cons[sb[j].inst] = 1;
        end
        cyc++;
    endtask

    task automatic check_all(input logic a, input logic f, input logic r);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("cons[%0d]@%0d", i, cyc), int'(cons_w[i]), int'(exp_cons[i]));
            chk($sformatf("pend[%0d]@%0d", i, cyc), pend_w[i], exp_pend[i]);
            chk($sformatf("busy[%0d]@%0d", i, cyc), int'(busy_w[i]), int'(exp_pend[i] != 0));
            chk($sformatf("drop[%0d]@%0d", i, cyc), int'(drop_w[i]), int'(exp_drop[i]));
            chk($sformatf("ovf[%0d]@%0d", i, cyc), int'(ovf_w[i]), int'(exp_ovf[i]));
        end
        chk($sformatf("ovl_cons@%0d", cyc), int'(cons_w[NI]), int'(a & ~f & ~r));
        chk($sformatf("ovl_pend@%0d", cyc), pend_w[NI], 0);
        chk($sformatf("ovl_busy@%0d", cyc), int'(busy_w[NI]), 0);
        chk($sformatf("ovl_drop@%0d", cyc), int'(drop_w[NI]), 0);
        chk($sformatf("ovl_ovf@%0d", cyc), int'(ovf_w[NI]), 0);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input logic a, input logic f, input logic r);
        ant = a;
        inj = f;
        rst = r;
        model_step(a, f, r);
        @(posedge clk);
        @(negedge clk);
        check_all(a, f, r);
    endtask

    task automatic check_vec(input vec_t v, input int k);
        chk($sformatf("vec%0d cons@%0d", v.tgt, k), int'(cons_w[v.tgt]), int'(v.cons[k]));
        chk($sformatf("vec%0d busy@%0d", v.tgt, k), int'(busy_w[v.tgt]), int'(v.busy[k]));
        chk($sformatf("vec%0d drop@%0d", v.tgt, k), int'(drop_w[v.tgt]), int'(v.drop[k]));
        chk($sformatf("vec%0d ovf@%0d", v.tgt, k), int'(ovf_w[v.tgt]), int'(v.ovf[k]));
    endtask

    vec_t scen [5];
    ovl_t ovl_tab [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        ant      = 1'b0;
        inj      = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < NI; i++) exp_ovf[i] = 0;

        // Bit k of ant/inj/rst drives edge k; bit k of an expectation is the value seen at edge k.
        scen[0] = '{ant: 16'h0020, inj: 16'h0000, rst: 16'h0000, tgt: 0,
                    cons: 17'h00100, busy: 17'h001C0, drop: 17'h0, ovf: 17'h0};
        scen[1] = '{ant: 16'h0007, inj: 16'h0000, rst: 16'h0000, tgt: 1,
                    cons: 17'h00018, busy: 17'h0001E, drop: 17'h00008, ovf: 17'h1FFF8};
        scen[2] = '{ant: 16'h03FF, inj: 16'h0000, rst: 16'h0000, tgt: 2,
                    cons: 17'h007FE, busy: 17'h007FE, drop: 17'h0, ovf: 17'h0};
        scen[3] = '{ant: 16'h0010, inj: 16'h0010, rst: 16'h0000, tgt: 3,
                    cons: 17'h0, busy: 17'h00060, drop: 17'h0, ovf: 17'h0};
        scen[4] = '{ant: 16'h0003, inj: 16'h0000, rst: 16'h0004, tgt: 4,
                    cons: 17'h0, busy: 17'h00006, drop: 17'h0, ovf: 17'h0};

        ovl_tab[0] = '{a: 1'b1, f: 1'b0, r: 1'b0, y: 1'b1};
        ovl_tab[1] = '{a: 1'b1, f: 1'b1, r: 1'b0, y: 1'b0};
        ovl_tab[2] = '{a: 1'b0, f: 1'b0, r: 1'b0, y: 1'b0};
        ovl_tab[3] = '{a: 1'b1, f: 1'b0, r: 1'b1, y: 1'b0};

        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 1'b0, 1'b1);
            check_vec(scen[s], 0);
            for (int k = 0; k < 16; k++) begin
                step(scen[s].ant[k], scen[s].inj[k], scen[s].rst[k]);
                check_vec(scen[s], k + 1);
            end
        end

        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 4; t++) begin
            step(ovl_tab[t].a, ovl_tab[t].f, ovl_tab[t].r);
            chk($sformatf("ovl_tab%0d", t), int'(cons_w[NI]), int'(ovl_tab[t].y));
        end

        // Dense random traffic with occasional failure injection and resets.
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 400; t++) begin
            step(logic'($urandom_range(3, 0) != 0), logic'($urandom_range(4, 0) == 0),
                 logic'($urandom_range(39, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
